// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon round sequencer: symbol type,
// state encoding and the LFSR feedback polynomial.
package simon_pkg;

  typedef logic [1:0] sym_t;

  // FSM state encoding (IDLE, GEN, PLAY, WAIT, WIN, LOSE)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_GEN  = 3'd1;
  localparam state_t ST_PLAY = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_WIN  = 3'd4;
  localparam state_t ST_LOSE = 3'd5;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit LFSR; only the two low bits are exported as the next
// candidate colour symbol.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] sym
);

  logic [7:0] value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value <= SEED;
    else        value <= lfsr_step(value);
  end

  assign sym = value[1:0];

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon round sequencer: grows a random colour sequence, plays it back and
// checks the player's presses. Define SIMON_TIMEOUT_EN to lose on WAIT idling.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         SHOW_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             btn_valid,
  input  logic [1:0]       btn,
  output logic             show_valid,
  output logic [1:0]       show_sym,
  output logic             busy,
  output logic [LEN_W-1:0] level,
  output logic             win,
  output logic             lose
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SLOT  = SHOW_CYCLES + GAP_CYCLES;
  localparam int CNT_W = $clog2(SLOT + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LVL   = LEN_W'(MAX_LEN);

  state_t           state;
  logic [LEN_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  sym_t             seq [2**IDX_W];
  sym_t             lfsr_sym;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] idx_inc;
  sym_t             cur_sym;
  sym_t             first_sym;
  logic             timeout;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .sym   (lfsr_sym)
  );

  assign last_idx = level - 1'b1;
  assign idx_inc  = idx + 1'b1;
  assign cur_sym  = seq[idx[IDX_W-1:0]];
  // In the first round seq[0] is written by the same edge that starts playback
  assign first_sym = (level == '0) ? lfsr_sym : seq[IDX_W'(0)];

`ifdef SIMON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout = (state == ST_WAIT) && !btn_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          to_cnt <= '0;
    else if (state != ST_WAIT || btn_valid) to_cnt <= '0;
    else if (!timeout)                   to_cnt <= to_cnt + 1'b1;
  end
`else
  // TIMEOUT_CYC has no effect in this build; WAIT never expires
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Sequence storage holds data only, so it carries no reset
  always_ff @(posedge clock) begin
    if (state == ST_GEN) seq[level[IDX_W-1:0]] <= lfsr_sym;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      level      <= '0;
      idx        <= '0;
      cnt        <= '0;
      show_valid <= 1'b0;
      show_sym   <= '0;
      busy       <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      case (state)
        ST_GEN: begin
          level      <= level + 1'b1;
          idx        <= '0;
          cnt        <= '0;
          show_valid <= 1'b1;
          show_sym   <= first_sym;
          state      <= ST_PLAY;
        end
        ST_PLAY: begin
          if (cnt == SLOT_LAST) begin
            cnt <= '0;
            if (idx >= last_idx) begin
              idx   <= '0;
              state <= ST_WAIT;
            end else begin
              idx        <= idx_inc;
              show_valid <= 1'b1;
              show_sym   <= seq[idx_inc[IDX_W-1:0]];
            end
          end else begin
            cnt        <= cnt + 1'b1;
            show_valid <= (cnt < SHOW_LAST);
            show_sym   <= (cnt < SHOW_LAST) ? cur_sym : 2'b00;
          end
        end
        ST_WAIT: begin
          if (btn_valid) begin
            if (btn != cur_sym) begin
              lose  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_LOSE;
            end else if (idx < last_idx) begin
              idx <= idx_inc;
            end else if (level < MAX_LVL) begin
              idx   <= '0;
              state <= ST_GEN;
            end else begin
              win   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_WIN;
            end
          end else if (timeout) begin
            lose  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_LOSE;
          end
        end
        default: begin
          if (start) begin
            level <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
            busy  <= 1'b1;
            idx   <= '0;
            cnt   <= '0;
            state <= ST_GEN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl: vector table for the first round plus
// hand-written multi-round sequences (win, lose, reset, WAIT idling).
module tb_simon_game_ctrl;

  localparam int LEN_W = 5;
  localparam int SLOT  = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             btn_valid = 1'b0;
  logic [1:0]       btn = 2'b00;
  logic             show_valid;
  logic [1:0]       show_sym;
  logic             busy;
  logic [LEN_W-1:0] level;
  logic             win;
  logic             lose;

  simon_game_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .btn_valid  (btn_valid),
    .btn        (btn),
    .show_valid (show_valid),
    .show_sym   (show_sym),
    .busy       (busy),
    .level      (level),
    .win        (win),
    .lose       (lose)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, one step per clock
  logic [7:0] mlfsr;
  logic [7:0] lfsr_prev = 8'h00;
  logic [1:0] exp_seq [16];
  int         lvl_seen = 0;
  int         sv_pulses = 0;
  logic       sv_last = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) mlfsr <= 8'hA5;
    else        mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  // A level increment means the previous cycle was GEN, which appended lfsr[1:0]
  always @(negedge clock) begin
    if (int'(level) == lvl_seen + 1 && lvl_seen < 16) exp_seq[lvl_seen] = lfsr_prev[1:0];
    lvl_seen = int'(level);
    if (show_valid && !sv_last) sv_pulses++;
    sv_last   = show_valid;
    lfsr_prev = mlfsr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       bv;
    logic [1:0] btn;
    logic       sv;
    logic       busy;
    logic [4:0] lv;
    logic       win;
    logic       lose;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  function automatic logic [10:0] pk(input logic sv, input logic [1:0] sym, input logic b,
                                     input logic [4:0] lv, input logic w, input logic l);
    return {sv, sym, b, lv, w, l};
  endfunction

  function automatic logic [10:0] outs();
    return {show_valid, show_sym, busy, level, win, lose};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic press(input logic [1:0] s);
    btn = s;
    btn_valid = 1'b1;
    tick();
    btn_valid = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_gen", int'(outs()), int'(pk(1'b0, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0)));
    tick();
    chk("start_first_show", int'(outs()), int'(pk(1'b1, exp_seq[0], 1'b1, 5'd1, 1'b0, 1'b0)));
  endtask

  // Entered on the first shown cycle of round r; leaves on the first WAIT cycle
  task automatic watch_play(input int r);
    int bad = 0;
    for (int k = 0; k < r; k++) begin
      for (int c = 0; c < SLOT; c++) begin
        if (outs() !== pk(c < 4, (c < 4) ? exp_seq[k] : 2'b00, 1'b1, 5'(r), 1'b0, 1'b0)) bad++;
        tick();
      end
    end
    chk($sformatf("playback_r%0d", r), bad, 0);
    chk($sformatf("wait_r%0d", r), int'(outs()), int'(pk(1'b0, 2'b00, 1'b1, 5'(r), 1'b0, 1'b0)));
  endtask

  task automatic answer(input int r, input int wrong_at);
    for (int k = 0; k < r; k++) begin
      if (k == wrong_at) begin
        press(~exp_seq[k]);
        chk("lose_on_mismatch", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'(r), 1'b0, 1'b1)));
        return;
      end
      press(exp_seq[k]);
    end
    if (r < 16) begin
      chk($sformatf("gen_r%0d", r), int'(outs()), int'(pk(1'b0, 2'b00, 1'b1, 5'(r), 1'b0, 1'b0)));
      tick();
      chk($sformatf("show_r%0d", r + 1), int'(outs()),
          int'(pk(1'b1, exp_seq[0], 1'b1, 5'(r + 1), 1'b0, 1'b0)));
    end else begin
      chk("win", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd16, 1'b1, 1'b0)));
    end
  endtask

  initial begin
    //            start bv  btn    sv  busy lv  win lose
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}; // press in IDLE ignored
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}; // start -> GEN
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0}; // show rises 2 edges after start
    tbl[3]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0}; // press in PLAY ignored
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0}; // start while busy ignored
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}; // gap
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}; // gap
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}; // WAIT
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}; // start in WAIT ignored
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};

    repeat (2) tick();
    chk("reset_state", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0)));
    reset = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      start     = tbl[i].start;
      btn_valid = tbl[i].bv;
      btn       = tbl[i].btn;
      tick();
      start     = 1'b0;
      btn_valid = 1'b0;
      chk($sformatf("vec%0d", i), int'(outs()),
          int'(pk(tbl[i].sv, tbl[i].sv ? exp_seq[0] : 2'b00, tbl[i].busy, tbl[i].lv,
                  tbl[i].win, tbl[i].lose)));
    end

    answer(1, -1);
    watch_play(2);

`ifdef SIMON_TIMEOUT_EN
    repeat (63) tick();
    chk("no_timeout_63", int'(lose), 0);
    tick();
    chk("timeout_lose", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd2, 1'b0, 1'b1)));
    start_game();
`else
    repeat (1000) tick();
    chk("still_wait_1000", int'(outs()), int'(pk(1'b0, 2'b00, 1'b1, 5'd2, 1'b0, 1'b0)));
    answer(2, -1);
`endif

    // Asynchronous reset in the middle of playback
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_async", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0)));
    tick();
    chk("reset_mid_play", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0)));
    reset = 1'b1;
    tick();

    // Wrong second press in round 3
    start_game();
    watch_play(1);
    answer(1, -1);
    watch_play(2);
    answer(2, -1);
    watch_play(3);
    answer(3, 1);
    press(exp_seq[0]);
    chk("press_in_lose", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd3, 1'b0, 1'b1)));

    // Full game to a win
    sv_pulses = 0;
    start_game();
    for (int r = 1; r <= 16; r++) begin
      watch_play(r);
      answer(r, -1);
    end
    chk("show_pulses", sv_pulses, 136);
    press(exp_seq[0]);
    tick();
    chk("win_sticky", int'(outs()), int'(pk(1'b0, 2'b00, 1'b0, 5'd16, 1'b1, 1'b0)));
    start_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
